// File: rtl/ecu_seq.sv
// ECU instruction sequencer: fetches opcode/operand bytes, steers the PC control
// inputs, assembles and range-checks jump targets, and watches the PC step count.
module ecu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  di,
    input  logic [2:0]  is,
    output logic        pc_oe,
    output logic        pc_lrc,
    output logic        pc_ini,
    output logic        pc_cub,
    output logic [15:0] pc_ai,
    output logic        ex_v,
    output logic        ex_last,
    output logic [7:0]  ex_op,
    output logic [15:0] ex_opd,
    output logic        flt,
    output logic        err
);

    localparam logic [2:0] FETCH = 3'd0;
    localparam logic [2:0] OPER1 = 3'd1;
    localparam logic [2:0] OPER2 = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] JUMP  = 3'd4;

    logic [2:0] state;
    logic [7:0] op;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [1:0] cnt;
    logic       tgt_ok;
    logic       last;

    function automatic logic in_range(input logic [15:0] t);
        in_range = (t >= 16'h8000) && (t <= 16'hFFFC);
    endfunction

    assign tgt_ok = in_range({hi, lo});
    assign last   = (state == EXEC) && (cnt == {1'b0, op[0]});

    // Mealy PC controls; forced idle while reset is held so the PC never steps
    always_comb begin
        pc_oe   = (state == FETCH) || (state == OPER1) || (state == OPER2);
        pc_lrc  = 1'b0;
        pc_ini  = 1'b0;
        pc_cub  = 1'b0;
        ex_v    = (state == EXEC);
        ex_last = last;
        if (rst) begin
            pc_cub = ((state == FETCH) && (di[7:6] != 2'b00)) ||
                     ((state == OPER1) && op[7]);
            pc_ini = last || ((state == JUMP) && !tgt_ok);
            pc_lrc = (state == JUMP) && tgt_ok;
        end
    end

    assign pc_ai  = {hi, lo};
    assign ex_op  = op;
    assign ex_opd = {hi, lo};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            op    <= 8'h00;
            lo    <= 8'h00;
            hi    <= 8'h00;
            cnt   <= 2'd0;
            flt   <= 1'b0;
            err   <= 1'b0;
        end else begin
            // step 7 auto-increments the PC, and FETCH must always see step 0
            if (((state == FETCH) && (is != 3'd0)) || (is == 3'd7))
                err <= 1'b1;
            case (state)
                FETCH: begin
                    op    <= di;
                    lo    <= 8'h00;
                    hi    <= 8'h00;
                    cnt   <= 2'd0;
                    state <= (di[7:6] == 2'b00) ? EXEC : OPER1;
                end
                OPER1: begin
                    lo    <= di;
                    state <= op[7] ? OPER2 : EXEC;
                end
                OPER2: begin
                    hi    <= di;
                    state <= op[6] ? JUMP : EXEC;
                end
                EXEC: begin
                    if (last) begin
                        cnt   <= 2'd0;
                        state <= FETCH;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                JUMP: begin
                    if (!tgt_ok)
                        flt <= 1'b1;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
